// File: rtl/wb_bus_router_if.sv
// wb_bus_router_if -- Wishbone master-side bus between a host and the router.
//
// Signals (names follow the router's external pin names):
//   wbs_cyc_i, wbs_stb_i, wbs_we_i  host cycle, strobe, write enable
//   wbs_sel_i[3:0]                  host byte select
//   wbs_adr_i[31:0], wbs_dat_i[31:0] host address and write data
//   wbs_ack_o                       router acknowledge (one-cycle pulse)
//   wbs_dat_o[31:0]                 router read data (valid while wbs_ack_o=1)
//   bus_err_o                       error pulse, only together with wbs_ack_o
//
// Handshake: the host raises cyc&stb with a stable request and holds it until
// it samples wbs_ack_o=1; ack is high for exactly one cycle per request and
// the response data/error are qualified by that ack. Dropping cyc before the
// ack abandons the request and no ack follows.
//
// Modports: master = host side, slave = router side.
interface wb_bus_router_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        bus_err_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o, bus_err_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o, bus_err_o
  );
endinterface

// File: rtl/wb_bus_router.sv
// wb_bus_router -- routes one Wishbone master to team design slots, the logic
// analyser control block and the GPIO control block.
//
// Address map: 0x30TT_xxxx -> design TT (1..NUM_TEAMS), 0x3100_xxxx -> LA,
// 0x3200_xxxx -> GPIO; anything else (team 0, team > NUM_TEAMS, other
// prefixes) is unmapped and answered at once with data 0 and bus_err_o.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wb (wb_bus_router_if.slave) host request / response
//   designs_stb, la_control_stb, gpio_control_stb  registered target strobes
//   slv_adr_o/slv_dat_o/slv_we_o/slv_sel_o         latched request (shared)
//   designs_*_o, la_control_*_o, gpio_control_*_o  target ack/data returns
//   state_o                     FSM state (0 IDLE, 1 ACTIVE, 2 RESP)
//
// Optional feature: define WB_ROUTER_TIMEOUT_EN to add a 16-bit ACTIVE-state
// watchdog that answers with TIMEOUT_DATA and bus_err_o after TIMEOUT_CYCLES
// cycles without a target ack. Without it ACTIVE waits for ack or cyc drop.
module wb_bus_router #(
  parameter int          NUM_TEAMS      = 12,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_DEAD
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_bus_router_if.slave      wb,
  output logic [NUM_TEAMS:0]  designs_stb,
  output logic                la_control_stb,
  output logic                gpio_control_stb,
  output logic [31:0]         slv_adr_o,
  output logic [31:0]         slv_dat_o,
  output logic                slv_we_o,
  output logic [3:0]          slv_sel_o,
  input  logic [31:0]         designs_dat_o [NUM_TEAMS:0],
  input  logic [31:0]         la_control_dat_o,
  input  logic [31:0]         gpio_control_dat_o,
  input  logic [NUM_TEAMS:0]  designs_ack_o,
  input  logic                la_control_ack_o,
  input  logic                gpio_control_ack_o,
  output logic [1:0]          state_o
);
  // Target index space: 0..NUM_TEAMS are design slots, then LA, then GPIO.
  localparam int NT       = NUM_TEAMS + 3;
  localparam int TW       = $clog2(NT);
  localparam int LA_IDX   = NUM_TEAMS + 1;
  localparam int GPIO_IDX = NUM_TEAMS + 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tgt_q, tgt_d;
  logic [NT-1:0]   stb_q, stb_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [31:0]     rdat_q, rdat_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d;

  logic            hit;
  logic [TW-1:0]   hit_idx;
  logic            sel_ack;
  logic [31:0]     sel_dat;
  logic            timeout_hit;

  // Address decode of the live host request.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    if (wb.wbs_adr_i[31:24] == 8'h30 && wb.wbs_adr_i[23:16] != 8'h00 &&
        int'(wb.wbs_adr_i[23:16]) <= NUM_TEAMS) begin
      hit     = 1'b1;
      hit_idx = TW'(wb.wbs_adr_i[23:16]);
    end else if (wb.wbs_adr_i[31:16] == 16'h3100) begin
      hit     = 1'b1;
      hit_idx = TW'(LA_IDX);
    end else if (wb.wbs_adr_i[31:16] == 16'h3200) begin
      hit     = 1'b1;
      hit_idx = TW'(GPIO_IDX);
    end
  end

  // Only the latched target's ack/data are looked at; other acks are ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int i = 0; i <= NUM_TEAMS; i++) begin
      if (int'(tgt_q) == i) begin
        sel_ack = designs_ack_o[i];
        sel_dat = designs_dat_o[i];
      end
    end
    if (int'(tgt_q) == LA_IDX) begin
      sel_ack = la_control_ack_o;
      sel_dat = la_control_dat_o;
    end
    if (int'(tgt_q) == GPIO_IDX) begin
      sel_ack = gpio_control_ack_o;
      sel_dat = gpio_control_dat_o;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb.wbs_cyc_i && wb.wbs_stb_i) begin
          if (hit) begin
            state_d = S_ACTIVE;
            tgt_d   = hit_idx;
            adr_d   = {16'b0, wb.wbs_adr_i[15:0]};
            dat_d   = wb.wbs_dat_i;
            we_d    = wb.wbs_we_i;
            sel_d   = wb.wbs_sel_i;
          end else begin
            state_d = S_RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdat_d  = '0;
          end
        end
      end
      S_ACTIVE: begin
        // Abort beats everything; a real ack beats a same-cycle timeout.
        if (!wb.wbs_cyc_i) begin
          state_d = S_IDLE;
        end else if (sel_ack) begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          rdat_d  = sel_dat;
        end else if (timeout_hit) begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdat_d  = TIMEOUT_DATA;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so they are high exactly
    // for the ACTIVE cycles and drop together with any exit from ACTIVE.
    stb_d = '0;
    for (int i = 0; i < NT; i++) begin
      stb_d[i] = (state_d == S_ACTIVE) && (int'(tgt_d) == i);
    end
  end

`ifdef WB_ROUTER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;

  // cnt_q counts ACTIVE cycles already spent without ack; the cycle in which
  // it reaches TIMEOUT_CYCLES-1 is the last one allowed.
  assign timeout_hit = (state_q == S_ACTIVE) && (cnt_q == TO_LAST);

  always_comb begin
    cnt_d = '0;
    if (state_q == S_ACTIVE && state_d == S_ACTIVE) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      stb_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
    end
  end

  assign designs_stb      = stb_q[NUM_TEAMS:0];
  assign la_control_stb   = stb_q[LA_IDX];
  assign gpio_control_stb = stb_q[GPIO_IDX];
  assign slv_adr_o        = adr_q;
  assign slv_dat_o        = dat_q;
  assign slv_we_o         = we_q;
  assign slv_sel_o        = sel_q;
  assign wb.wbs_ack_o     = ack_q;
  assign wb.bus_err_o     = err_q;
  assign wb.wbs_dat_o     = rdat_q;
  assign state_o          = state_q;
endmodule

// File: tb/tb_wb_bus_router.sv
module tb_wb_bus_router;
  localparam int NUM_TEAMS = 12;
  localparam int NT        = NUM_TEAMS + 3;
  localparam int LA_BIT    = NUM_TEAMS + 1;
  localparam int GPIO_BIT  = NUM_TEAMS + 2;
  localparam logic [31:0] LA_DATA   = 32'h1A1A_0001;
  localparam logic [31:0] GPIO_DATA = 32'h6B10_0002;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  wb_bus_router_if bus();
  logic [NUM_TEAMS:0] designs_stb;
  logic               la_stb, gpio_stb;
  logic [31:0]        slv_adr, slv_dat;
  logic               slv_we;
  logic [3:0]         slv_sel;
  logic [31:0]        des_dat [NUM_TEAMS:0];
  logic [NUM_TEAMS:0] des_ack;
  logic               la_ack, gpio_ack;
  logic [1:0]         state;

  wb_bus_router #(
    .NUM_TEAMS(NUM_TEAMS), .TIMEOUT_CYCLES(4), .TIMEOUT_DATA(32'hDEAD_DEAD)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus.slave),
    .designs_stb(designs_stb), .la_control_stb(la_stb), .gpio_control_stb(gpio_stb),
    .slv_adr_o(slv_adr), .slv_dat_o(slv_dat), .slv_we_o(slv_we), .slv_sel_o(slv_sel),
    .designs_dat_o(des_dat), .la_control_dat_o(LA_DATA), .gpio_control_dat_o(GPIO_DATA),
    .designs_ack_o(des_ack), .la_control_ack_o(la_ack), .gpio_control_ack_o(gpio_ack),
    .state_o(state)
  );

  // ---------------- target model ----------------
  // Every target acks after slv_wait wait cycles of its own strobe; rogue_*
  // inject acks unrelated to any strobe.
  logic [NT-1:0]      stb_vec;
  int                 slv_wait = 0;
  int                 slv_cnt  = 0;
  logic [NUM_TEAMS:0] rogue_des_ack = '0;
  assign stb_vec = {gpio_stb, la_stb, designs_stb};

  always @(posedge clk) slv_cnt <= (|stb_vec) ? slv_cnt + 1 : 0;

  always_comb begin
    des_ack = '0;
    for (int i = 0; i <= NUM_TEAMS; i++)
      des_ack[i] = (designs_stb[i] && slv_cnt == slv_wait) || rogue_des_ack[i];
    la_ack   = la_stb && slv_cnt == slv_wait;
    gpio_ack = gpio_stb && slv_cnt == slv_wait;
  end

  initial begin
    for (int i = 0; i <= NUM_TEAMS; i++) des_dat[i] = 32'hD000_0000 + i;
    des_dat[3] = 32'h1234_5678;
  end

  // ---------------- scoreboard / monitor ----------------
  int          checks = 0;
  int          failures = 0;
  logic [32:0] exp_q[$];        // {bus_err, data}
  int          stb_cyc = 0;
  logic [NT-1:0] stb_or = '0;
  logic        prev_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] exp;
    if (|stb_vec) begin
      stb_cyc++;
      stb_or |= stb_vec;
    end
    if (bus.wbs_ack_o) begin
      checks++;
      if (prev_ack) begin
        failures++;
        $display("FAIL ack_width: ack high on consecutive cycles");
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack: got err=%0b data=0x%08h expected no ack",
                 bus.bus_err_o, bus.wbs_dat_o);
      end else begin
        exp = exp_q.pop_front();
        if ({bus.bus_err_o, bus.wbs_dat_o} !== exp) begin
          failures++;
          $display("FAIL response: got err=%0b data=0x%08h expected err=%0b data=0x%08h",
                   bus.bus_err_o, bus.wbs_dat_o, exp[32], exp[31:0]);
        end
      end
    end
    prev_ack = bus.wbs_ack_o;
  end

  // ---------------- driver ----------------
  task automatic drive_req(input logic [31:0] adr, input logic [31:0] dat,
                           input logic we, input logic [3:0] sel);
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = sel;  bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;
    stb_cyc = 0; stb_or = '0;
  endtask

  task automatic release_bus();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
  endtask

  // lat = number of rising edges from the request cycle to the ack cycle.
  task automatic do_txn(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                        input logic [3:0] sel, input int max_cyc,
                        output int lat, output bit got);
    drive_req(adr, dat, we, sel);
    lat = 0; got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (bus.wbs_ack_o) got = 1'b1;
    end
    @(posedge clk); #1;
    release_bus();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    bit got;
    release_bus();
    bus.wbs_we_i = 1'b0; bus.wbs_sel_i = '0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
    chk("rst_err", 32'(bus.bus_err_o), 32'd0);
    chk("rst_dat", bus.wbs_dat_o, 32'd0);
    chk("rst_stb", 32'(stb_vec), 32'd0);
    chk("rst_slv_adr", slv_adr, 32'd0);
    chk("rst_slv_dat", slv_dat, 32'd0);
    chk("rst_slv_we_sel", {27'd0, slv_we, slv_sel}, 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Design 3 read, two wait cycles.
    slv_wait = 2;
    exp_q.push_back({1'b0, 32'h1234_5678});
    do_txn(32'h3003_0010, 32'h0, 1'b0, 4'hF, 20, lat, got);
    chk("d3_got", 32'(got), 32'd1);
    chk("d3_lat", 32'(lat), 32'd4);
    chk("d3_stb_cyc", 32'(stb_cyc), 32'd3);
    chk("d3_stb_or", 32'(stb_or), 32'(1 << 3));
    chk("d3_slv_adr", slv_adr, 32'h0000_0010);
    chk("d3_slv_we", 32'(slv_we), 32'd0);

    // GPIO write, zero wait.
    slv_wait = 0;
    exp_q.push_back({1'b0, GPIO_DATA});
    do_txn(32'h3200_0004, 32'hA5A5_A5A5, 1'b1, 4'hF, 20, lat, got);
    chk("gpio_lat", 32'(lat), 32'd2);
    chk("gpio_stb_cyc", 32'(stb_cyc), 32'd1);
    chk("gpio_stb_or", 32'(stb_or), 32'(1 << GPIO_BIT));
    chk("gpio_slv_dat", slv_dat, 32'hA5A5_A5A5);
    chk("gpio_slv_we", 32'(slv_we), 32'd1);
    chk("gpio_slv_sel", 32'(slv_sel), 32'hF);
    chk("gpio_slv_adr", slv_adr, 32'h0000_0004);

    // Unmapped: team 0, team 13, unknown prefix.
    exp_q.push_back({1'b1, 32'h0});
    do_txn(32'h3000_0000, 32'h0, 1'b0, 4'hF, 20, lat, got);
    chk("team0_lat", 32'(lat), 32'd1);
    chk("team0_stb", 32'(stb_or), 32'd0);
    exp_q.push_back({1'b1, 32'h0});
    do_txn(32'h300D_0000, 32'h0, 1'b0, 4'hF, 20, lat, got);
    chk("team13_lat", 32'(lat), 32'd1);
    chk("team13_stb", 32'(stb_or), 32'd0);
    exp_q.push_back({1'b1, 32'h0});
    do_txn(32'h3300_0000, 32'h0, 1'b1, 4'h3, 20, lat, got);
    chk("unmap_lat", 32'(lat), 32'd1);
    chk("unmap_slv_adr_held", slv_adr, 32'h0000_0004);

    // Highest team slot, zero wait.
    exp_q.push_back({1'b0, 32'hD000_000C});
    do_txn(32'h300C_0008, 32'h0, 1'b0, 4'h1, 20, lat, got);
    chk("d12_lat", 32'(lat), 32'd2);
    chk("d12_stb_or", 32'(stb_or), 32'(1 << 12));
    chk("d12_slv_sel", 32'(slv_sel), 32'h1);

    // LA read with a foreign ack from design 1 present throughout.
    slv_wait = 1;
    rogue_des_ack[1] = 1'b1;
    exp_q.push_back({1'b0, LA_DATA});
    do_txn(32'h3100_0040, 32'h0, 1'b0, 4'hF, 20, lat, got);
    rogue_des_ack[1] = 1'b0;
    chk("la_rogue_lat", 32'(lat), 32'd3);
    chk("la_rogue_stb_or", 32'(stb_or), 32'(1 << LA_BIT));

    // LA never acks.
    slv_wait = 1000;
`ifdef WB_ROUTER_TIMEOUT_EN
    exp_q.push_back({1'b1, 32'hDEAD_DEAD});
    do_txn(32'h3100_0000, 32'h0, 1'b0, 4'hF, 20, lat, got);
    chk("to_got", 32'(got), 32'd1);
    chk("to_lat", 32'(lat), 32'd5);
    chk("to_stb_cyc", 32'(stb_cyc), 32'd4);
`else
    do_txn(32'h3100_0000, 32'h0, 1'b0, 4'hF, 100, lat, got);
    chk("noto_got", 32'(got), 32'd0);
    chk("noto_stb_cyc", 32'(stb_cyc), 32'd100);
    @(posedge clk); @(negedge clk);
    chk("noto_abort_stb", 32'(stb_vec), 32'd0);
`endif

    // Design 5, cyc dropped in the second ACTIVE cycle.
    drive_req(32'h3005_0000, 32'h0, 1'b0, 4'hF);
    @(posedge clk);
    @(posedge clk); #1 release_bus();
    @(negedge clk);
    chk("abort_stb_still", 32'(designs_stb[5]), 32'd1);
    @(negedge clk);
    chk("abort_stb_drop", 32'(stb_vec), 32'd0);
    chk("abort_state", 32'(state), 32'd0);
    repeat (3) @(negedge clk);
    slv_wait = 0;
    exp_q.push_back({1'b0, LA_DATA});
    do_txn(32'h3100_0008, 32'h0, 1'b0, 4'hF, 20, lat, got);
    chk("after_abort_lat", 32'(lat), 32'd2);

    // Reset one cycle before the slave ack, then a late ack.
    slv_wait = 2;
    drive_req(32'h3007_0020, 32'h0, 1'b0, 4'hF);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    rogue_des_ack[7] = 1'b1;
    release_bus();
    @(negedge clk);
    chk("mrst_ack", 32'(bus.wbs_ack_o), 32'd0);
    chk("mrst_dat", bus.wbs_dat_o, 32'd0);
    chk("mrst_stb", 32'(stb_vec), 32'd0);
    chk("mrst_slv_adr", slv_adr, 32'd0);
    chk("mrst_state", 32'(state), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_ack_ignored", 32'(bus.wbs_ack_o), 32'd0);
    end
    rogue_des_ack[7] = 1'b0;

    slv_wait = 0;
    exp_q.push_back({1'b0, 32'hD000_0001});
    do_txn(32'h3001_0000, 32'h0, 1'b0, 4'hF, 20, lat, got);
    chk("recover_lat", 32'(lat), 32'd2);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
